// File: rtl/bam_pkg.sv
// ============================================================================
// Module      : bam_pkg
// Description : Shared widths, state encoding and slot arithmetic for the
//               BAM decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bam_pkg;

    localparam int BAM_DW          = 8;
    localparam int BAM_PRESC_W     = 3;
    localparam int BAM_FRAME_TICKS = 255;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bam_state_t;

    // Last slot-counter value of a slot: slot k lasts 2^k ticks.
    function automatic logic [7:0] slot_limit(input logic [2:0] bit_idx);
        return (8'd1 << bit_idx) - 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bam_tick_gen.sv
// ============================================================================
// Module      : bam_tick_gen
// Description : Prescaled tick generator; one-cycle tick every 2^mode clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bam_tick_gen
    import bam_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic                   i_clear,
    input  logic [BAM_PRESC_W-1:0] i_mode,
    output logic                   o_tick
);

    logic [6:0] r_cnt;
    logic [6:0] w_limit;
    logic       w_hit;

    // Mode 7 wraps 1<<7 to 0 in seven bits, so the limit still lands on 127.
    assign w_limit = (7'd1 << i_mode) - 7'd1;
    assign w_hit   = (r_cnt == w_limit);
    assign o_tick  = w_hit & ~i_clear;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_cnt <= 7'd0;
        end else if (i_clear || w_hit) begin
            r_cnt <= 7'd0;
        end else begin
            r_cnt <= r_cnt + 7'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bam_decoder.sv
// ============================================================================
// Module      : bam_decoder
// Description : Recovers the 8-bit duty word from each MSB-first BAM frame.
//               Optional slot consistency check: BAM_DEC_CONSISTENCY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bam_decoder
    import bam_pkg::*;
#(
    parameter int DW = BAM_DW
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic                   i_on,
    input  logic [BAM_PRESC_W-1:0] i_presc_mode,
    input  logic                   i_bam_enable,
    input  logic                   i_signal,
    output logic [DW-1:0]          o_duty_cycle,
    output logic                   o_valid,
    output logic                   o_error,
    output logic                   o_busy
);

    bam_state_t             r_state;
    logic [BAM_PRESC_W-1:0] r_presc;
    logic [2:0]             r_bit;
    logic [7:0]             r_slot;
    logic [DW-1:0]          r_shift;
    logic [DW-1:0]          r_duty;
    logic                   r_valid;
    logic                   r_busy;

    logic          w_active;
    logic          w_clear;
    logic          w_tick;
    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_err_final;
    logic [DW-1:0] w_word;

    assign w_active    = i_on & i_bam_enable;
    // A prescale change restarts the frame exactly like an inactive cycle.
    assign w_clear     = ~w_active | (i_presc_mode != r_presc);
    assign w_slot_end  = w_tick & (r_slot == slot_limit(r_bit));
    assign w_frame_end = w_slot_end & (r_bit == 3'd0);

    always_comb begin
        w_word        = r_shift;
        w_word[r_bit] = i_signal;
    end

    bam_tick_gen u_tick_gen (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_clear  (w_clear),
        .i_mode   (i_presc_mode),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_bit   <= 3'd7;
            r_slot  <= 8'd0;
            r_shift <= '0;
            r_duty  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_presc <= i_presc_mode;
            r_valid <= 1'b0;
            r_state <= w_active ? RUN : IDLE;
            r_busy  <= (r_state == RUN);
            if (w_clear) begin
                r_bit  <= 3'd7;
                r_slot <= 8'd0;
            end else if (w_slot_end) begin
                r_shift[r_bit] <= i_signal;
                r_slot         <= 8'd0;
                r_bit          <= w_frame_end ? 3'd7 : r_bit - 3'd1;
                if (w_frame_end && !w_err_final) begin
                    r_duty  <= w_word;
                    r_valid <= 1'b1;
                end
            end else if (w_tick) begin
                r_slot <= r_slot + 8'd1;
            end
        end
    end

`ifdef BAM_DEC_CONSISTENCY_CHECK_EN
    logic r_first;
    logic r_err;
    logic r_error;
    logic w_mismatch;

    // The first tick of a slot is the reference for every later tick in it.
    assign w_mismatch  = w_tick & (r_slot != 8'd0) & (i_signal != r_first);
    assign w_err_final = r_err | w_mismatch;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_first <= 1'b0;
            r_err   <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_error <= 1'b0;
            if (w_clear) begin
                r_err <= 1'b0;
            end else if (w_tick) begin
                if (r_slot == 8'd0) begin
                    r_first <= i_signal;
                end
                if (w_frame_end) begin
                    r_error <= w_err_final;
                    r_err   <= 1'b0;
                end else if (w_mismatch) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign o_error = r_error;
`else
    assign w_err_final = 1'b0;
    assign o_error     = 1'b0;
`endif

    assign o_duty_cycle = r_duty;
    assign o_valid      = r_valid;
    assign o_busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bam_decoder.sv
// ============================================================================
// Module      : tb_bam_decoder
// Description : Self-checking bench for bam_decoder with a transmitter model
//               and an expected-frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bam_decoder;

    typedef struct packed {
        logic       err;
        logic [7:0] word;
    } exp_t;

    logic       clk;
    logic       i_arst_n;
    logic       i_on;
    logic [2:0] i_presc_mode;
    logic       i_bam_enable;
    logic       i_signal;
    logic [7:0] o_duty_cycle;
    logic       o_valid;
    logic       o_error;
    logic       o_busy;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_flags = 0;
    int         last_valid_cyc = 0;
    int         prev_valid_cyc = 0;
    logic [7:0] exp_duty = 8'h00;

    bam_decoder dut (
        .i_clk        (clk),
        .i_arst_n     (i_arst_n),
        .i_on         (i_on),
        .i_presc_mode (i_presc_mode),
        .i_bam_enable (i_bam_enable),
        .i_signal     (i_signal),
        .o_duty_cycle (o_duty_cycle),
        .o_valid      (o_valid),
        .o_error      (o_error),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every flag pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (i_arst_n && (o_valid || o_error)) begin
            exp_t e;
            n_flags++;
            checks++;
            if (o_valid && o_error) begin
                errors++;
                $display("FAIL flags_exclusive valid=%0b error=%0b required one", o_valid, o_error);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flag valid=%0b error=%0b duty=%02h required no flag",
                         o_valid, o_error, o_duty_cycle);
            end else begin
                e = exp_q.pop_front();
                if (o_error !== e.err || o_duty_cycle !== e.word) begin
                    errors++;
                    $display("FAIL frame_result error=%0b duty=%02h required error=%0b duty=%02h",
                             o_error, o_duty_cycle, e.err, e.word);
                end
            end
            if (o_valid) begin
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Transmitter model; stop_at truncates the frame, glitch_at inverts one cycle.
    task automatic send_frame(input logic [7:0] w, input int mode, input int stop_at,
                              input int glitch_at);
        int n = 0;
        for (int b = 7; b >= 0; b--) begin
            for (int k = 0; k < ((1 << b) << mode); k++) begin
                if (n == stop_at) return;
                i_signal = (n == glitch_at) ? ~w[b] : w[b];
                @(posedge clk);
                #1;
                n++;
            end
        end
    endtask

    task automatic push_ok(input logic [7:0] w);
        exp_q.push_back('{err: 1'b0, word: w});
        exp_duty = w;
    endtask

    task automatic go_idle_and_drain(input string name);
        i_bam_enable = 1'b0;
        i_signal     = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        i_arst_n = 1'b0; i_on = 1'b1; i_presc_mode = 3'd0;
        i_bam_enable = 1'b0; i_signal = 1'b0;
        step(3);
        checks++;
        if (o_duty_cycle !== 8'h00 || o_valid !== 1'b0 || o_error !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs duty=%02h valid=%0b error=%0b busy=%0b required all 0",
                     o_duty_cycle, o_valid, o_error, o_busy);
        end
        i_arst_n = 1'b1;
        step(2);
    endtask

    task automatic test_mode0();
        int t0;
        t0 = cyc;
        i_bam_enable = 1'b1;
        push_ok(8'hA5);
        send_frame(8'hA5, 0, -1, -1);
        push_ok(8'hA5);
        send_frame(8'hA5, 0, -1, -1);
        step(1);
        checks++;
        if (prev_valid_cyc - t0 != 255) begin
            errors++;
            $display("FAIL mode0_first_latency got=%0d required 255", prev_valid_cyc - t0);
        end
        checks++;
        if (last_valid_cyc - prev_valid_cyc != 255) begin
            errors++;
            $display("FAIL mode0_period got=%0d required 255", last_valid_cyc - prev_valid_cyc);
        end
        go_idle_and_drain("mode0");
    endtask

    task automatic test_mode3();
        int t0;
        i_presc_mode = 3'd3;
        step(2);
        t0 = cyc;
        i_bam_enable = 1'b1;
        push_ok(8'h01);
        send_frame(8'h01, 3, -1, -1);
        step(1);
        checks++;
        if (last_valid_cyc - t0 != 2040) begin
            errors++;
            $display("FAIL mode3_latency got=%0d required 2040", last_valid_cyc - t0);
        end
        go_idle_and_drain("mode3");
        i_presc_mode = 3'd0;
        step(2);
    endtask

    task automatic test_back_to_back();
        i_bam_enable = 1'b1;
        push_ok(8'h00);
        send_frame(8'h00, 0, -1, -1);
        push_ok(8'hFF);
        send_frame(8'hFF, 0, -1, -1);
        step(1);
        checks++;
        if (o_duty_cycle !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_final duty=%02h required ff", o_duty_cycle);
        end
        go_idle_and_drain("b2b");
    endtask

    task automatic test_glitch();
        i_bam_enable = 1'b1;
`ifdef BAM_DEC_CONSISTENCY_CHECK_EN
        exp_q.push_back('{err: 1'b1, word: exp_duty});
`else
        push_ok(8'h40);
`endif
        // Bit-6 slot occupies frame cycles 128..191 in mode 0.
        send_frame(8'h40, 0, -1, 150);
        go_idle_and_drain("glitch");
    endtask

    task automatic test_abort();
        int f0;
        f0 = n_flags;
        i_bam_enable = 1'b1;
        send_frame(8'h5A, 0, 10, -1);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_run busy=%0b required 1", o_busy);
        end
        send_frame(8'h5A, 0, 90, -1);
        i_bam_enable = 1'b0;
        step(5);
        checks++;
        if (o_busy !== 1'b0 || n_flags != f0) begin
            errors++;
            $display("FAIL abort_discard busy=%0b flags=%0d required busy 0 flags %0d",
                     o_busy, n_flags - f0, 0);
        end
        i_bam_enable = 1'b1;
        push_ok(8'h5A);
        send_frame(8'h5A, 0, -1, -1);
        go_idle_and_drain("abort");
    endtask

    task automatic test_presc_change();
        int f0;
        int t0;
        f0 = n_flags;
        i_bam_enable = 1'b1;
        send_frame(8'h3C, 0, 50, -1);
        i_presc_mode = 3'd1;
        i_signal     = 1'b0;
        step(1);
        checks++;
        if (n_flags != f0) begin
            errors++;
            $display("FAIL presc_no_flag flags=%0d required 0", n_flags - f0);
        end
        t0 = cyc;
        push_ok(8'h3C);
        send_frame(8'h3C, 1, -1, -1);
        step(1);
        checks++;
        if (last_valid_cyc - t0 != 510) begin
            errors++;
            $display("FAIL presc_restart_latency got=%0d required 510", last_valid_cyc - t0);
        end
        go_idle_and_drain("presc");
        i_presc_mode = 3'd0;
        step(2);
    endtask

    task automatic test_reset_mid();
        checks++;
        if (o_duty_cycle !== exp_duty) begin
            errors++;
            $display("FAIL pre_reset_duty duty=%02h required %02h", o_duty_cycle, exp_duty);
        end
        i_bam_enable = 1'b1;
        send_frame(8'h77, 0, 100, -1);
        i_arst_n = 1'b0;
        #2;
        checks++;
        if (o_duty_cycle !== 8'h00 || o_valid !== 1'b0 || o_error !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset duty=%02h valid=%0b error=%0b busy=%0b required all 0",
                     o_duty_cycle, o_valid, o_error, o_busy);
        end
        i_bam_enable = 1'b0;
        i_signal     = 1'b0;
        step(2);
        i_arst_n = 1'b1;
        step(2);
        exp_duty = 8'h00;
        i_bam_enable = 1'b1;
        push_ok(8'h96);
        send_frame(8'h96, 0, -1, -1);
        go_idle_and_drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_glitch();
        test_abort();
        test_presc_change();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog_timeout cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/bam_decoder.md
# bam_decoder

Receive-side counterpart of the one-channel BAM generator. Samples a binary-angle-modulated line and recovers the 8-bit duty-cycle word from each frame. A frame is 8 slots, MSB first: slot k lasts 2^k prescaled ticks, for 255 ticks per frame. Used on the VGA/GPIO side to display or check the value a BAM channel is actually emitting.

## Interface
Parameters:
- `DW`, default 8: duty-cycle width; fixed at 8, exposed only for package consistency.

Ports:
- `i_clk` input 1: system clock (50 MHz).
- `i_arst_n` input 1: asynchronous, active-low reset.
- `i_on` input 1: decoder enable (CONFIG[0] of the decoder).
- `i_presc_mode` input 3: tick prescale. Divide by 2^mode, 1:1 through 1:128. Must match the transmitter's setting.
- `i_bam_enable` input 1: transmitter's enable indication. The low-to-high edge marks frame start.
- `i_signal` input 1: BAM line, synchronous to `i_clk`.
- `o_duty_cycle` output 8: last successfully decoded word; held between frames.
- `o_valid` output 1: one-cycle pulse when `o_duty_cycle` is updated.
- `o_error` output 1: one-cycle pulse at the end of a frame that failed its consistency check.
- `o_busy` output 1: high while a frame is being decoded.

## Operation
- `active` = `i_on & i_bam_enable`.
- **States:**
  - IDLE: `active`=0. Tick counter, slot counter and bit index are cleared; bit index = 7.
  - RUN: `active`=1.
  - IDLE→RUN on the first cycle `active` is high. RUN→IDLE on any cycle `active` is low; the partial frame is discarded and no flag is raised.
- **Tick generation:** a 7-bit counter counts 0..(2^mode−1). The tick is high on the cycle the counter equals 2^mode−1, then the counter wraps to 0. With mode 0 the tick is high every cycle.
- **Slot counting:** on each tick the slot counter increments. When slot counter == 2^bit−1 on a tick:
  - store `i_signal` into `shift[bit]`;
  - clear the slot counter;
  - decrement the bit index.
- **Frame end:** after bit 0 is stored, on the next cycle:
  - no error: `o_duty_cycle` ← `shift`, `o_valid`=1;
  - error: `o_error`=1 and `o_duty_cycle` is unchanged.
- After frame end, the bit index reloads to 7 and the next frame starts without a gap.
- **Prescale change:** if `i_presc_mode` differs from its registered copy, the frame aborts and all counters restart at bit 7, tick count 0, on the following cycle. No flag is raised.
- **Arithmetic:** slot limit = (1<<bit)−1, 8-bit unsigned; the slot counter is 8 bits. The bit index wraps 0→7 only through the frame-end reload.
- **Reset values:** `o_duty_cycle`=0, `o_valid`=0, `o_error`=0, `o_busy`=0. Internal state = IDLE, bit index = 7, shift = 0.

## Timing
- Frame length = 255 × 2^mode cycles, measured from the first RUN cycle.
- With mode 0, the bit-7 sample is taken on RUN cycle 127 (0-based). `o_valid` pulses on RUN cycle 255.
- `o_busy` is a registered copy of state == RUN.
- Frame-end latency is 1 cycle after the final sample.
- `o_valid` and `o_error` are never high together.
- If `active` drops on the frame-end sampling cycle, the frame is discarded.
- If `i_arst_n` is asserted mid-frame, all outputs return to their reset values immediately.

## Configuration
- `BAM_DEC_CONSISTENCY_CHECK_EN` defined:
  - every tick inside a slot compares `i_signal` with the first sample of that slot;
  - any mismatch sets a per-frame error flag, cleared at frame start;
  - the error flag drives `o_error` and suppresses the `o_duty_cycle` update.
- Undefined:
  - only the last tick of each slot is sampled;
  - `o_error` is tied to 0;
  - every completed frame produces `o_valid`.

## Structure
- Package `bam_pkg`:
  - `BAM_DW`=8 and `BAM_PRESC_W`=3;
  - state typedef {IDLE, RUN};
  - constant `BAM_FRAME_TICKS`=255.
- Sub-module `bam_tick_gen`: prescaled tick generator. Inputs are clock, reset, clear and mode; the output is a one-cycle tick. The frame FSM, slot counter, shift register and check logic stay in `bam_decoder`.

## Test plan
- Mode 0, transmitter-accurate stimulus of 0xA5 → after 255 RUN cycles, `o_valid` pulses once and `o_duty_cycle`=0xA5; repeated frames give a pulse every 255 cycles.
- Mode 3 (1:8), word 0x01 → line low for 254×8 cycles, then high for 8 cycles → `o_valid` on RUN cycle 2040 and `o_duty_cycle`=0x01.
- Words 0x00 and 0xFF back-to-back → 0x00, then 0xFF, with no gap frame.
- With check enabled, a 1-cycle glitch inside the bit-6 slot of 0x40 → `o_error` pulses, `o_valid` stays low, and `o_duty_cycle` keeps its previous value. With check disabled, `o_valid` pulses with `o_duty_cycle`=0x40.
- Drop `i_bam_enable` at RUN cycle 100, then restart it → no flags for the first frame; the next full frame decodes correctly.
- Change `i_presc_mode` 0→1 at RUN cycle 50, and separately assert `i_arst_n`=0 mid-frame → frame restarts with no flag; reset clears all outputs to 0.
